scalar_sched: RTL and testbench

//  Round-robin scheduler sharing one scalar vector ALU (IL.FL fixed point, SIZE lanes) among NREQ requesters.

---
 rtl/scalar_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/scalar_sched.sv | 165 ++++++++++++++++
 tb/tb_scalar_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_pkg.sv
// Shared fixed-point geometry and state encodings for the scalar vector ALU scheduler.
package scalar_pkg;

    localparam int IL   = 8;
    localparam int FL   = 12;
    localparam int SIZE = 16;
    localparam int W    = IL + FL;

    typedef logic signed [W-1:0] fix_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB,
        MUL,
        DIV
    } alu_mode_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'b00,
        A_BUSY = 2'b01,
        A_DONE = 2'b10
    } alu_state_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;
    logic           w_any;

    // Rotate so that bit 0 of w_rot is the requester at the pointer.
    assign w_req2 = {req, req};
    assign w_rot  = w_req2[{1'b0, pointer} +: N];
    assign w_any  = |req;

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum     = {1'b0, pointer} + {1'b0, w_off};
    assign grant_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = w_any && (grant_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/scalar_sched.sv
// Round-robin scheduler sharing one scalar vector ALU among NREQ requesters.
// Optional feature: define SCALAR_SCHED_TIMEOUT_EN to drop responses not taken within TIMEOUT cycles.
module scalar_sched
    import scalar_pkg::*;
#(
    parameter int NREQ = 4
`ifdef SCALAR_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ-1:0][1:0]             req_mode,
    input  logic [NREQ-1:0][SIZE-1:0][W-1:0] req_in1,
    input  logic [NREQ-1:0][SIZE-1:0][W-1:0] req_in2,
    output logic [NREQ-1:0]                  req_ready,
    output logic [NREQ-1:0]                  rsp_valid,
    input  logic [NREQ-1:0]                  rsp_taken,
    output logic [SIZE-1:0][W-1:0]           rsp_out,
    output logic                             rsp_drop,
    output logic [1:0]                       alu_mode,
    output logic [SIZE-1:0][W-1:0]           alu_in1,
    output logic [SIZE-1:0][W-1:0]           alu_in2,
    output logic                             alu_input_ready,
    output logic                             alu_output_taken,
    input  logic [1:0]                       alu_state,
    input  logic [SIZE-1:0][W-1:0]           alu_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e           r_state;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_ptr;
    logic [1:0]             r_cur_mode;
    logic [SIZE-1:0][W-1:0] r_rsp_out;
    logic [NREQ-1:0]        r_rsp_valid;

    logic [NREQ-1:0]        w_grant;
    logic [IW-1:0]          w_grant_idx;
    logic [NREQ-1:0]        w_owner_oh;
    logic [IW-1:0]          w_ptr_next;
    logic                   w_any;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_alu_idle;
    logic                   w_alu_done;
    logic                   w_taken;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .req       (req_valid),
        .pointer   (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
            assign w_owner_oh[gi] = (r_owner == IW'(gi));
        end
    endgenerate

    assign w_any      = |w_grant;
    assign w_alu_idle = (alu_state == A_IDLE);
    assign w_alu_done = (alu_state == A_DONE);
    assign w_issue    = (r_state == ISSUE);
    assign w_accept   = w_issue && w_alu_idle;
    assign w_taken    = |(rsp_taken & w_owner_oh);
    assign w_ptr_next = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    // Start and release are mutually exclusive because they decode different states.
    assign alu_input_ready  = w_accept;
    assign req_ready        = w_accept ? w_owner_oh : '0;
    assign alu_output_taken = (r_state == WAIT) && w_alu_done;

    assign alu_in1   = w_issue ? req_in1[r_owner] : '0;
    assign alu_in2   = w_issue ? req_in2[r_owner] : '0;
    assign alu_mode  = r_cur_mode;
    assign rsp_out   = r_rsp_out;
    assign rsp_valid = r_rsp_valid;

`ifdef SCALAR_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_rsp_drop;

    assign rsp_drop = r_rsp_drop;
`else
    assign rsp_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cur_mode  <= '0;
            r_rsp_out   <= '0;
            r_rsp_valid <= '0;
`ifdef SCALAR_SCHED_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_drop  <= 1'b0;
`endif
        end else begin
`ifdef SCALAR_SCHED_TIMEOUT_EN
            r_rsp_drop <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_grant_idx;
                        r_cur_mode <= req_mode[w_grant_idx];
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_alu_idle) begin
                        r_state <= WAIT;
`ifdef SCALAR_SCHED_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
`ifdef SCALAR_SCHED_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    if (w_alu_done) begin
                        r_rsp_out   <= alu_out;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= RESP;
`ifdef SCALAR_SCHED_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                RESP: begin
                    if (w_taken) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end
`ifdef SCALAR_SCHED_TIMEOUT_EN
                    // The counter holds TIMEOUT-1 on the last RESP cycle, so the drop lands TIMEOUT cycles after entry.
                    else if (r_tmo_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= '0;
                        r_rsp_drop  <= 1'b1;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_sched.sv
// Directed self-checking bench for scalar_sched with a behavioural handshake ALU.
module tb_scalar_sched;
    import scalar_pkg::*;

    localparam int NREQ = 4;
    localparam int VW   = SIZE * W;

    typedef logic [SIZE-1:0][W-1:0] vec_t;

    logic                             clk = 1'b0;
    logic                             reset = 1'b1;
    logic [NREQ-1:0]                  req_valid = '0;
    logic [NREQ-1:0][1:0]             req_mode = '0;
    logic [NREQ-1:0][SIZE-1:0][W-1:0] req_in1 = '0;
    logic [NREQ-1:0][SIZE-1:0][W-1:0] req_in2 = '0;
    logic [NREQ-1:0]                  req_ready;
    logic [NREQ-1:0]                  rsp_valid;
    logic [NREQ-1:0]                  rsp_taken = '0;
    vec_t                             rsp_out;
    logic                             rsp_drop;
    logic [1:0]                       alu_mode;
    vec_t                             alu_in1;
    vec_t                             alu_in2;
    logic                             alu_input_ready;
    logic                             alu_output_taken;
    logic [1:0]                       alu_state;
    vec_t                             alu_out;

    logic [1:0] m_state;
    vec_t       m_out;
    logic       force_busy = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scalar_sched #(
        .NREQ(NREQ)
`ifdef SCALAR_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_mode         (req_mode),
        .req_in1          (req_in1),
        .req_in2          (req_in2),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_taken        (rsp_taken),
        .rsp_out          (rsp_out),
        .rsp_drop         (rsp_drop),
        .alu_mode         (alu_mode),
        .alu_in1          (alu_in1),
        .alu_in2          (alu_in2),
        .alu_input_ready  (alu_input_ready),
        .alu_output_taken (alu_output_taken),
        .alu_state        (alu_state),
        .alu_out          (alu_out)
    );

    function automatic vec_t alu_calc(input logic [1:0] mode, input vec_t a, input vec_t b);
        vec_t r;
        logic signed [2*W-1:0] x, y, p;
        r = '0;
        for (int k = 0; k < SIZE; k++) begin
            x = {{W{a[k][W-1]}}, a[k]};
            y = {{W{b[k][W-1]}}, b[k]};
            case (mode)
                2'b00:   p = x + y;
                2'b01:   p = x - y;
                2'b10:   p = (x * y) >>> FL;
                default: p = (y == 0) ? '1 : (x <<< FL) / y;
            endcase
            r[k] = p[W-1:0];
        end
        return r;
    endfunction

    // Behavioural ALU: busy the cycle after start, done the next, idle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_state <= A_IDLE;
            m_out   <= '0;
        end else begin
            case (m_state)
                A_IDLE: if (alu_input_ready) begin
                    m_out   <= alu_calc(alu_mode, alu_in1, alu_in2);
                    m_state <= A_BUSY;
                end
                A_BUSY: m_state <= A_DONE;
                A_DONE: if (alu_output_taken) m_state <= A_IDLE;
                default: m_state <= A_IDLE;
            endcase
        end
    end

    assign alu_state = force_busy ? 2'b01 : m_state;
    assign alu_out   = m_out;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        rsp_taken  = '0;
        force_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            exp_v;
        int              g_idx [5];
        int              r_idx [5];
        logic [W-1:0]    r_val [5];
        int              exp_g [5];
        logic [W-1:0]    exp_r [5];
        int              ng, nr, cyc, n_otk;

        exp_g = '{0, 1, 2, 3, 0};
        exp_r = '{20'h03000, 20'h02000, 20'h04000, 20'h05000, 20'h03000};

        // ---------------- Test 1: single requester, add ----------------
        do_reset();
        settle();
        check_eq("rst_req_ready", VW'(req_ready), VW'(0));
        check_eq("rst_rsp_valid", VW'(rsp_valid), VW'(0));
        check_eq("rst_alu_mode", VW'(alu_mode), VW'(0));
        check_eq("rst_rsp_out", VW'(rsp_out), VW'(0));
        check_eq("rst_alu_start", VW'(alu_input_ready), VW'(0));
        check_eq("rst_rsp_drop", VW'(rsp_drop), VW'(0));
        for (int k = 0; k < SIZE; k++) begin
            req_in1[1][k] = W'(k << 12);
            req_in2[1][k] = W'(1 << 12);
            exp_v[k]      = W'((k + 1) << 12);
        end
        req_mode[1] = 2'b00;
        req_valid   = 4'b0010;
        settle();
        check_eq("t1_c0_ready", VW'(req_ready), VW'(0));
        step(); settle();
        check_eq("t1_c1_ready", VW'(req_ready), VW'(4'b0010));
        check_eq("t1_c1_start", VW'(alu_input_ready), VW'(1));
        check_eq("t1_c1_in1_lane5", VW'(alu_in1[5]), VW'(20'h05000));
        req_valid = '0;
        step(); settle();
        check_eq("t1_c2_ready", VW'(req_ready), VW'(0));
        check_eq("t1_c2_release", VW'(alu_output_taken), VW'(0));
        step(); settle();
        check_eq("t1_c3_release", VW'(alu_output_taken), VW'(1));
        check_eq("t1_c3_rsp_valid", VW'(rsp_valid), VW'(0));
        step(); settle();
        check_eq("t1_c4_rsp_valid", VW'(rsp_valid), VW'(4'b0010));
        check_eq("t1_c4_rsp_out", VW'(rsp_out), VW'(exp_v));
        $display("t1: owner=%0d rsp_out[0]=%0h rsp_out[15]=%0h", oh2idx(rsp_valid), rsp_out[0], rsp_out[15]);
        rsp_taken = 4'b0010;
        step(); settle();
        check_eq("t1_c5_rsp_valid", VW'(rsp_valid), VW'(0));
        rsp_taken = '0;

        // ---------------- Test 2: all requesters, instant take ----------------
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            req_mode[r] = 2'(r);
            for (int k = 0; k < SIZE; k++) begin
                req_in1[r][k] = W'((r + 2) << 12);
                req_in2[r][k] = W'(1 << 12);
            end
        end
        req_valid = 4'b1111;
        rsp_taken = 4'b1111;
        ng = 0; nr = 0; cyc = 0;
        while ((ng < 5 || nr < 5) && cyc < 80) begin
            settle();
            if (|req_ready && ng < 5) begin
                g_idx[ng] = oh2idx(req_ready);
                ng++;
            end
            if (|rsp_valid && nr < 5) begin
                r_idx[nr] = oh2idx(rsp_valid);
                r_val[nr] = rsp_out[0];
                $display("t2: txn %0d owner=%0d rsp_out[0]=%0h", nr, r_idx[nr], r_val[nr]);
                nr++;
            end
            step();
            cyc++;
        end
        check_eq("t2_grant_budget", VW'(ng), VW'(5));
        check_eq("t2_rsp_budget", VW'(nr), VW'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < ng) check_eq($sformatf("t2_grant%0d", i), VW'(g_idx[i]), VW'(exp_g[i]));
            if (i < nr) begin
                check_eq($sformatf("t2_owner%0d", i), VW'(r_idx[i]), VW'(exp_g[i]));
                check_eq($sformatf("t2_result%0d", i), VW'(r_val[i]), VW'(exp_r[i]));
            end
        end
        req_valid = '0;
        rsp_taken = '0;

        // ---------------- Test 3: owner 2 delays take, req 0 pending ----------------
        do_reset();
        for (int k = 0; k < SIZE; k++) begin
            req_in1[2][k] = W'(k << 12);
            req_in2[2][k] = W'(2 << 12);
            exp_v[k]      = W'((k + 2) << 12);
            req_in1[0][k] = W'(9 << 12);
            req_in2[0][k] = W'(4 << 12);
        end
        req_mode[2] = 2'b00;
        req_mode[0] = 2'b01;
        req_valid   = 4'b0100;
        n_otk       = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_otk += int'(alu_output_taken);
            if (req_ready[2]) req_valid[2] = 1'b0;
            step();
        end
        settle();
        req_valid[0] = 1'b1;
        for (int h = 0; h < 10; h++) begin
            settle();
            n_otk += int'(alu_output_taken);
            check_eq($sformatf("t3_hold%0d_valid", h), VW'(rsp_valid), VW'(4'b0100));
            check_eq($sformatf("t3_hold%0d_out", h), VW'(rsp_out), VW'(exp_v));
            check_eq($sformatf("t3_hold%0d_ready", h), VW'(req_ready), VW'(0));
            rsp_taken = (h == 9) ? 4'b0100 : 4'b1011;
            step();
        end
        settle();
        $display("t3: owner=2 rsp_out[0]=%0h taken after hold", exp_v[0]);
        check_eq("t3_idle_valid", VW'(rsp_valid), VW'(0));
        check_eq("t3_idle_ready", VW'(req_ready), VW'(0));
        check_eq("t3_release_once", VW'(n_otk), VW'(1));
        rsp_taken = '0;
        step(); settle();
        check_eq("t3_req0_grant", VW'(req_ready), VW'(4'b0001));
        check_eq("t3_req0_mode", VW'(alu_mode), VW'(2'b01));
        req_valid = '0;

        // ---------------- Test 4: reset while in WAIT ----------------
        step(); settle();
        check_eq("t4_wait_mode", VW'(alu_mode), VW'(2'b01));
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check_eq("t4_req_ready", VW'(req_ready), VW'(0));
        check_eq("t4_rsp_valid", VW'(rsp_valid), VW'(0));
        check_eq("t4_rsp_out", VW'(rsp_out), VW'(0));
        check_eq("t4_alu_mode", VW'(alu_mode), VW'(0));
        check_eq("t4_alu_in1", VW'(alu_in1), VW'(0));
        check_eq("t4_start", VW'(alu_input_ready), VW'(0));
        check_eq("t4_release", VW'(alu_output_taken), VW'(0));
        check_eq("t4_drop", VW'(rsp_drop), VW'(0));
        req_valid = 4'b1010;
        step(); settle();
        check_eq("t4_ptr0_grant", VW'(req_ready), VW'(4'b0010));
        $display("t4: reset in WAIT, next grant=%0d", oh2idx(req_ready));
        req_valid = '0;

        // ---------------- Test 5: ALU busy during ISSUE ----------------
        do_reset();
        force_busy = 1'b1;
        for (int k = 0; k < SIZE; k++) begin
            req_in1[3][k] = W'(3 << 12);
            req_in2[3][k] = W'(2 << 12);
        end
        req_mode[3] = 2'b10;
        req_valid   = 4'b1000;
        step();
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("t5_busy%0d_start", i), VW'(alu_input_ready), VW'(0));
            check_eq($sformatf("t5_busy%0d_ready", i), VW'(req_ready), VW'(0));
            step();
        end
        force_busy = 1'b0;
        settle();
        check_eq("t5_free_start", VW'(alu_input_ready), VW'(1));
        check_eq("t5_free_ready", VW'(req_ready), VW'(4'b1000));
        check_eq("t5_mode", VW'(alu_mode), VW'(2'b10));
        req_valid = '0;
        step(); step(); step(); settle();
        check_eq("t5_rsp_valid", VW'(rsp_valid), VW'(4'b1000));
        check_eq("t5_result", VW'(rsp_out[0]), VW'(20'h06000));
        $display("t5: owner=3 rsp_out[0]=%0h", rsp_out[0]);
        rsp_taken = 4'b1000;
        step();
        rsp_taken = '0;

`ifdef SCALAR_SCHED_TIMEOUT_EN
        // ---------------- Test 6: response timeout ----------------
        do_reset();
        for (int k = 0; k < SIZE; k++) begin
            req_in1[1][k] = W'(1 << 12);
            req_in2[1][k] = W'(1 << 12);
            req_in1[2][k] = W'(1 << 12);
            req_in2[2][k] = W'(1 << 12);
        end
        req_mode[1] = 2'b00;
        req_mode[2] = 2'b00;
        req_valid   = 4'b0110;
        step(); settle();
        check_eq("t6_grant1", VW'(req_ready), VW'(4'b0010));
        req_valid = 4'b0100;
        step(); step(); step(); settle();
        check_eq("t6_rsp_valid", VW'(rsp_valid), VW'(4'b0010));
        for (int k = 1; k <= 8; k++) begin
            step(); settle();
            if (k < 8) begin
                check_eq($sformatf("t6_k%0d_drop", k), VW'(rsp_drop), VW'(0));
                check_eq($sformatf("t6_k%0d_valid", k), VW'(rsp_valid), VW'(4'b0010));
            end else begin
                check_eq("t6_drop_pulse", VW'(rsp_drop), VW'(1));
                check_eq("t6_drop_valid", VW'(rsp_valid), VW'(0));
            end
        end
        step(); settle();
        check_eq("t6_drop_clear", VW'(rsp_drop), VW'(0));
        check_eq("t6_next_grant", VW'(req_ready), VW'(4'b0100));
        $display("t6: owner=1 dropped, next grant=%0d", oh2idx(req_ready));
        req_valid = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
